// File: rtl/bsg_arb_burst_lock.sv
// bsg_arb_burst_lock
//
// Shares one valid/ready output channel among inputs_p requesters. A fixed-priority
// pick is made among valid requesters. Once the winner's first beat is accepted, the
// grant is locked to it until its last beat is accepted. Multi-beat bursts from
// different sources therefore never interleave on the shared channel.
//
// Optional feature (macro BSG_ARB_BURST_LOCK_TIMEOUT_EN):
//   When defined, a watchdog counts LOCKED cycles with no accepted beat. After timeout_p
//   such cycles it forces the lock back to IDLE and pulses timeout_o for one cycle.
//   When undefined, no counter is built, timeout_o is tied 0 and a lock is held
//   indefinitely.
//
// Parameters:
//   inputs_p   - number of requesters (>= 1)
//   width_p    - data width per beat
//   lo_to_hi_p - 1: index 0 has highest priority; 0: index inputs_p-1 has highest priority
//   timeout_p  - watchdog limit in stalled cycles (>= 2)
//
// Ports:
//   clk_i      - clock
//   reset_n_i  - synchronous active-low reset
//   v_i        - per-requester beat valid
//   last_i     - per-requester "this beat ends the burst"
//   data_i     - per-requester beat data, slice k is [k*width_p +: width_p]
//   yumi_o     - one-hot, beat consumed from requester k
//   v_o        - output beat valid
//   last_o     - output beat is the last of its burst
//   data_o     - output beat data
//   ready_i    - downstream accepts a beat this cycle
//   grant_id_o - index of the requester currently driving v_o/data_o
//   locked_o   - burst in progress (registered)
//   timeout_o  - one-cycle pulse on a forced lock release (registered)

module bsg_arb_burst_lock #(
    parameter int unsigned inputs_p   = 4,
    parameter int unsigned width_p    = 8,
    parameter bit          lo_to_hi_p = 1'b1,
    parameter int unsigned timeout_p  = 16,
    localparam int unsigned IdW       = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [inputs_p-1:0]           v_i,
    input  logic [inputs_p-1:0]           last_i,
    input  logic [inputs_p*width_p-1:0]   data_i,
    output logic [inputs_p-1:0]           yumi_o,
    output logic                          v_o,
    output logic                          last_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          ready_i,
    output logic [IdW-1:0]                grant_id_o,
    output logic                          locked_o,
    output logic                          timeout_o
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] own_q, own_d;
    logic [IdW-1:0] win;
    logic [IdW-1:0] sel;
    logic           fire;
    logic           expire;

    // Fixed-priority pick among valid requesters; defaults to 0 when none are valid.
    always_comb begin
        int unsigned idx;
        logic        found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < inputs_p; k++) begin
            idx = lo_to_hi_p ? k : (inputs_p - 1 - k);
            if (!found && v_i[idx]) begin
                win   = idx[IdW-1:0];
                found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        case (state_q)
            StIdle: begin
                // Single-beat bursts never take the lock.
                if (fire && !last_o) begin
                    state_d = StLocked;
                    own_d   = sel;
                end
            end
            StLocked: begin
                // An accepted beat takes precedence over the watchdog.
                if (fire) begin
                    if (last_o) begin
                        state_d = StIdle;
                    end
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic; purely combinational from v_i/ready_i through the selected requester.
    always_comb begin
        sel        = (state_q == StLocked) ? own_q : win;
        v_o        = reset_n_i & v_i[sel];
        last_o     = reset_n_i & last_i[sel];
        data_o     = data_i[sel*width_p +: width_p];
        grant_id_o = sel;
        fire       = v_o & ready_i;
        yumi_o     = '0;
        yumi_o[sel] = fire;
        locked_o   = (state_q == StLocked);
    end

`ifdef BSG_ARB_BURST_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(timeout_p + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    always_comb begin
        expire = (state_q == StLocked) && !fire && (cnt_q == CntW'(timeout_p - 1));
        // Counter only runs while locked and stalled; any beat, entry or expiry clears it.
        if ((state_q != StLocked) || fire || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
